// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states and the
// operand forwarding select codes.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10,
        ST_STEP = 2'b11
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EXE = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

    function automatic logic is_issuing_state(state_t s);
        return (s == ST_RUN) || (s == ST_STEP);
    endfunction

endpackage

// File: rtl/hazard_cmp.sv
// Compares one ID source register against the EXE and WB shadow destinations;
// reports a raw hit and the forwarding code (EXE has priority over WB).
module hazard_cmp
    import pipe_ctrl_pkg::*;
(
    input  logic       id_valid,
    input  logic       use_src,
    input  logic [4:0] rs,
    input  logic       exe_v,
    input  logic [4:0] exe_waddr,
    input  logic       wb_v,
    input  logic [4:0] wb_waddr,
    output logic       hit,
    output logic [1:0] fwd
);

    logic src_live;
    logic exe_match;
    logic wb_match;

    // r0 is hardwired zero, so it can never depend on an older write
    assign src_live  = id_valid && use_src && (rs != 5'd0);
    assign exe_match = src_live && exe_v && (rs == exe_waddr);
    assign wb_match  = src_live && wb_v  && (rs == wb_waddr);
    assign hit       = exe_match || wb_match;

    always_comb begin
        fwd = FWD_RF;
        if (exe_match) begin
            fwd = FWD_EXE;
        end else if (wb_match) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Issue/stall/forward control for a 4-stage IF/ID/EXE/WB pipeline with
// run/halt/single-step sequencing. Define PIPE_FORWARD_EN to forward instead of stall.
//
// state | meaning
// IDLE  | after reset, nothing issues until start
// RUN   | free-running issue, stalls on RAW hazards
// HALT  | issue stopped, shadow pipeline drains
// STEP  | issue exactly one instruction, then back to HALT
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        halt_req,
    input  logic        step_req,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic        id_wen,
    input  logic [4:0]  id_waddr,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        bubble,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt
);

`ifdef PIPE_FORWARD_EN
    localparam logic FWD_EN = 1'b1;
`else
    localparam logic FWD_EN = 1'b0;
`endif

    state_t     state_q;
    state_t     state_d;

    logic       exe_v;
    logic [4:0] exe_waddr;
    logic       wb_v;
    logic [4:0] wb_waddr;

    logic       hit_a;
    logic       hit_b;
    logic [1:0] cmp_fwd_a;
    logic [1:0] cmp_fwd_b;

    logic       active;
    logic       stall;
    logic       issue;
    logic       exe_load;

    hazard_cmp u_cmp_a (
        .id_valid  (id_valid),
        .use_src   (id_use_rs1),
        .rs        (id_rs1),
        .exe_v     (exe_v),
        .exe_waddr (exe_waddr),
        .wb_v      (wb_v),
        .wb_waddr  (wb_waddr),
        .hit       (hit_a),
        .fwd       (cmp_fwd_a)
    );

    hazard_cmp u_cmp_b (
        .id_valid  (id_valid),
        .use_src   (id_use_rs2),
        .rs        (id_rs2),
        .exe_v     (exe_v),
        .exe_waddr (exe_waddr),
        .wb_v      (wb_v),
        .wb_waddr  (wb_waddr),
        .hit       (hit_b),
        .fwd       (cmp_fwd_b)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start)    state_d = ST_RUN;
            ST_RUN:  if (halt_req) state_d = ST_HALT;
            ST_HALT: begin
                if (start)         state_d = ST_RUN;
                else if (step_req) state_d = ST_STEP;
            end
            ST_STEP: if (issue)    state_d = ST_HALT;
            default:               state_d = ST_IDLE;
        endcase
    end

    // With forwarding every hazard is resolved by the bypass, so nothing stalls
    always_comb begin
        active  = is_issuing_state(state_q);
        stall   = active && !FWD_EN && (hit_a || hit_b);
        issue   = active && !stall;
        pc_en   = issue;
        ifid_en = issue;
        bubble  = !issue;
        fwd_a   = FWD_EN ? cmp_fwd_a : FWD_RF;
        fwd_b   = FWD_EN ? cmp_fwd_b : FWD_RF;
    end

    assign state    = state_q;
    assign exe_load = issue && id_valid && id_wen && (id_waddr != 5'd0);

    // Shadow destinations keep advancing even when halted, so the pipe drains
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exe_v     <= 1'b0;
            exe_waddr <= 5'd0;
            wb_v      <= 1'b0;
            wb_waddr  <= 5'd0;
        end else begin
            wb_v      <= exe_v;
            wb_waddr  <= exe_waddr;
            exe_v     <= exe_load;
            exe_waddr <= exe_load ? id_waddr : 5'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= 16'd0;
        end else if ((state_q == ST_IDLE) && start) begin
            stall_cnt <= 16'd0;
        end else if (stall && (stall_cnt != STALL_CNT_MAX)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1; sole clock, all state on rising edge.
REQ-002 SHALL have port rst, input, 1; reset, asynchronous, active-low.
REQ-003 SHALL have port start, input, 1; pulse, begin/resume issue.
REQ-004 SHALL have port halt_req, input, 1; stop issuing.
REQ-005 SHALL have port step_req, input, 1; issue exactly one instruction while halted.
REQ-006 SHALL have port id_valid, input, 1; ID stage holds a real instruction.
REQ-007 SHALL have ports id_rs1, id_rs2, input, 5 each; ID source registers.
REQ-008 SHALL have ports id_use_rs1, id_use_rs2, input, 1 each; source actually read.
REQ-009 SHALL have ports id_wen, input, 1, and id_waddr, input, 5; ID destination.
REQ-010 SHALL have port pc_en, output, 1; PC update enable.
REQ-011 SHALL have port ifid_en, output, 1; IF/ID register load enable.
REQ-012 SHALL have port bubble, output, 1; force NOP into ID/EXE register.
REQ-013 SHALL have ports fwd_a, fwd_b, output, 2 each; operand source select, 00 regfile, 01 EXE result, 10 WB result.
REQ-014 SHALL have port state, output, 2; 00 IDLE, 01 RUN, 10 HALT, 11 STEP.
REQ-015 SHALL have port stall_cnt, output, 16; hazard-bubble counter.

Function
REQ-016 SHALL model a 4-stage IF/ID/EXE/WB pipeline; regfile written at end of WB, no write-through.
REQ-017 SHALL hold shadow registers exe_v/exe_waddr and wb_v/wb_waddr; each edge wb <= exe; exe <= (issue & id_valid & id_wen & id_waddr!=0, id_waddr), otherwise exe_v <= 0.
REQ-018 SHALL define hazard per source: id_valid & use & rs!=0 & ((exe_v & rs==exe_waddr) | (wb_v & rs==wb_waddr)); r0 never hazards.
REQ-019 SHALL compute pc_en, ifid_en, bubble, fwd_* combinationally in the same cycle (zero latency).
REQ-020 SHALL, in IDLE and HALT: pc_en=0, ifid_en=0, bubble=1; shadow pipeline keeps draining.
REQ-021 SHALL, in RUN and STEP: stall = any hazard; pc_en=ifid_en=!stall; bubble=stall; issue = !stall.
REQ-022 SHALL transition IDLE->RUN on start; step_req/halt_req ignored in IDLE.
REQ-023 SHALL transition RUN->HALT on halt_req; halt_req wins over start in the same cycle.
REQ-024 SHALL transition HALT->RUN on start, HALT->STEP on step_req; start wins when both asserted.
REQ-025 SHALL remain in STEP while stalled and go STEP->HALT on the cycle the instruction issues.
REQ-026 SHALL increment stall_cnt on each cycle with stall=1 in RUN/STEP, saturating at 0xFFFF; cleared on IDLE->RUN.

Reset
REQ-027 SHALL, on rst low, immediately clear: state=IDLE, exe_v=wb_v=0, waddrs=0, stall_cnt=0, fwd_a=fwd_b=00; thus pc_en=0, ifid_en=0, bubble=1.
REQ-028 SHALL discard any in-flight step or stall on reset mid-operation; leave IDLE only via start after rst high.

Configuration
REQ-029 SHALL, with PIPE_FORWARD_EN defined, drive fwd_*=01 on EXE match, else 10 on WB match (EXE priority), and never stall.
REQ-030 SHALL, without PIPE_FORWARD_EN, hold fwd_a=fwd_b=00 and stall per REQ-021.

Structure
REQ-031 SHALL place the state encoding and FWD_* constants in shared package pipe_ctrl_pkg.
REQ-032 SHALL use one sub-module hazard_cmp (one source vs EXE/WB shadow, returns hit and fwd code), instantiated twice.

Verification
REQ-033 SHALL cover reset then start: state 00->01, pc_en=1, bubble=0, stall_cnt=0.
REQ-034 SHALL cover no-forward RAW: issue wen r3, next ID reads rs1=r3 -> 2 stall cycles, stall_cnt=2, then issue.
REQ-035 SHALL cover PIPE_FORWARD_EN: same sequence -> fwd_a=01, then with one gap fwd_a=10, stall_cnt=0.
REQ-036 SHALL cover r0: write r0 then read r0 -> no stall, fwd 00.
REQ-037 SHALL cover halt/step: halt_req -> HALT, bubble=1; step_req with hazard -> STEP held 2 cycles, one issue, back to HALT.
REQ-038 SHALL cover rst low mid-stall -> all outputs at reset values within the same cycle.
